// File: rtl/lsq_ctrl_if.sv
// Data-memory bus between the load/store queue (master) and the memory port (slave).
// Signal names keep the lsq-side view, so the _o fields are driven by the queue controller.
interface lsq_ctrl_if #(
    parameter int C_XLEN = 32
);
    logic              mem_req_o;
    logic              mem_gnt_i;
    logic              mem_we_o;
    logic [C_XLEN-1:0] mem_addr_o;
    logic [3:0]        mem_be_o;
    logic [C_XLEN-1:0] mem_wdata_o;
    logic              mem_rvalid_i;
    logic [C_XLEN-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/lsq_ctrl.sv
// Load/store queue controller: in-order FIFO of ex-stage memory ops, one bus transaction
// outstanding at a time, load data extended and written back to regfile port b.
module lsq_ctrl #(
    parameter int C_XLEN  = 32,
    parameter int C_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              clk_en_i,
    input  logic              resetb_i,
    input  logic              exs_lsq_push_i,
    output logic              exs_lsq_full_o,
    input  logic              exs_lsq_load_i,
    input  logic [2:0]        exs_lsq_funct3_i,
    input  logic [C_XLEN-1:0] exs_lsq_addr_i,
    input  logic [C_XLEN-1:0] exs_lsq_wdata_i,
    input  logic [4:0]        exs_lsq_regd_addr_i,
    output logic              lsq_empty_o,
    lsq_ctrl_if.master        mem,
    output logic              lsq_reg_wr_o,
    output logic [4:0]        lsq_reg_addr_o,
    output logic [C_XLEN-1:0] lsq_reg_data_o
);

    localparam int PW = $clog2(C_DEPTH);
    localparam int CW = $clog2(C_DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(C_DEPTH);
    localparam logic [CW-1:0] ONE        = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state;

    logic              q_load   [C_DEPTH];
    logic [2:0]        q_funct3 [C_DEPTH];
    logic [C_XLEN-1:0] q_addr   [C_DEPTH];
    logic [C_XLEN-1:0] q_wdata  [C_DEPTH];
    logic [4:0]        q_regd   [C_DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] sel;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push_ok;
    logic          pop;
    logic          head_load;
    logic          load_bus;

    function automatic logic [3:0] lane_be(input logic ld, input logic [2:0] f3, input logic [1:0] off);
        if (ld) return 4'b1111;
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [C_XLEN-1:0] lane_wdata(input logic [2:0] f3, input logic [C_XLEN-1:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [C_XLEN-1:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                                   input logic [C_XLEN-1:0] rd);
        logic [C_XLEN-1:0] sh;
        sh = rd >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'b0, sh[7:0]};
            3'b101:  return {16'b0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    assign push_ok     = exs_lsq_push_i & ~exs_lsq_full_o;
    assign rd_ptr_nxt  = rd_ptr + 1'b1;
    assign head_load   = q_load[rd_ptr];
    assign pop         = ((state == REQ) && mem.mem_gnt_i && !head_load) ||
                         ((state == WAIT) && mem.mem_rvalid_i);
    // Leaving IDLE presents the head; chaining after a pop presents the entry behind it.
    assign sel         = (state == IDLE) ? rd_ptr : rd_ptr_nxt;
    assign load_bus    = ((state == IDLE) && (count != '0)) || (pop && (count > ONE));
    assign lsq_empty_o = (count == '0) && (state == IDLE);

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!push_ok && pop) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clk_en_i && push_ok) begin
            q_load[wr_ptr]   <= exs_lsq_load_i;
            q_funct3[wr_ptr] <= exs_lsq_funct3_i;
            q_addr[wr_ptr]   <= exs_lsq_addr_i;
            q_wdata[wr_ptr]  <= exs_lsq_wdata_i;
            q_regd[wr_ptr]   <= exs_lsq_regd_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state           <= IDLE;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            exs_lsq_full_o  <= 1'b0;
            mem.mem_req_o   <= 1'b0;
            mem.mem_we_o    <= 1'b0;
            mem.mem_addr_o  <= '0;
            mem.mem_be_o    <= '0;
            mem.mem_wdata_o <= '0;
            lsq_reg_wr_o    <= 1'b0;
            lsq_reg_addr_o  <= '0;
            lsq_reg_data_o  <= '0;
        end else if (clk_en_i) begin
            count          <= count_nxt;
            exs_lsq_full_o <= (count_nxt == FULL_COUNT);
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr_nxt;

            if (load_bus) begin
                mem.mem_we_o    <= !q_load[sel];
                mem.mem_addr_o  <= {q_addr[sel][C_XLEN-1:2], 2'b00};
                mem.mem_be_o    <= lane_be(q_load[sel], q_funct3[sel], q_addr[sel][1:0]);
                mem.mem_wdata_o <= lane_wdata(q_funct3[sel], q_wdata[sel]);
            end

            lsq_reg_wr_o <= 1'b0;
            if ((state == WAIT) && mem.mem_rvalid_i) begin
                lsq_reg_wr_o   <= (q_regd[rd_ptr] != 5'd0);
                lsq_reg_addr_o <= q_regd[rd_ptr];
                lsq_reg_data_o <= load_ext(q_funct3[rd_ptr], q_addr[rd_ptr][1:0], mem.mem_rdata_i);
            end

            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state         <= REQ;
                        mem.mem_req_o <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem.mem_gnt_i) begin
                        if (head_load) begin
                            state         <= WAIT;
                            mem.mem_req_o <= 1'b0;
                        end else if (count <= ONE) begin
                            state         <= IDLE;
                            mem.mem_req_o <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid_i) begin
                        if (count > ONE) begin
                            state         <= REQ;
                            mem.mem_req_o <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    mem.mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsq_ctrl.sv
// Testbench for lsq_ctrl: table of ops with hand-derived bus/write-back expectations,
// a memory slave that checks bus requests against a scoreboard, plus corner-case sequences.
module tb_lsq_ctrl;

    typedef struct {
        logic        load;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  regd;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_wb;
        logic [31:0] e_data;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct packed {
        logic [4:0]  regd;
        logic [31:0] data;
    } wb_exp_t;

    logic        clk_i;
    logic        clk_en_i;
    logic        resetb_i;
    logic        exs_lsq_push_i;
    logic        exs_lsq_full_o;
    logic        exs_lsq_load_i;
    logic [2:0]  exs_lsq_funct3_i;
    logic [31:0] exs_lsq_addr_i;
    logic [31:0] exs_lsq_wdata_i;
    logic [4:0]  exs_lsq_regd_addr_i;
    logic        lsq_empty_o;
    logic        lsq_reg_wr_o;
    logic [4:0]  lsq_reg_addr_o;
    logic [31:0] lsq_reg_data_o;

    lsq_ctrl_if #(.C_XLEN(32)) mem_if ();

    lsq_ctrl #(.C_XLEN(32), .C_DEPTH(4)) dut (
        .clk_i               (clk_i),
        .clk_en_i            (clk_en_i),
        .resetb_i            (resetb_i),
        .exs_lsq_push_i      (exs_lsq_push_i),
        .exs_lsq_full_o      (exs_lsq_full_o),
        .exs_lsq_load_i      (exs_lsq_load_i),
        .exs_lsq_funct3_i    (exs_lsq_funct3_i),
        .exs_lsq_addr_i      (exs_lsq_addr_i),
        .exs_lsq_wdata_i     (exs_lsq_wdata_i),
        .exs_lsq_regd_addr_i (exs_lsq_regd_addr_i),
        .lsq_empty_o         (lsq_empty_o),
        .mem                 (mem_if),
        .lsq_reg_wr_o        (lsq_reg_wr_o),
        .lsq_reg_addr_o      (lsq_reg_addr_o),
        .lsq_reg_data_o      (lsq_reg_data_o)
    );

    bus_exp_t    busq[$];
    wb_exp_t     wbq[$];
    logic [31:0] rdq[$];

    int checks = 0;
    int errors = 0;
    int req_cycles = 0;
    int grants = 0;
    int wb_count = 0;
    int rv_cnt = 0;
    int rv_delay = 2;
    int stall = 0;
    bit gnt_en = 1'b1;
    bit spur = 1'b0;
    logic [31:0] rv_data = '0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit accept);
        if (accept) begin
            busq.push_back('{~v.load, v.e_addr, v.e_be, v.e_wdata});
            if (v.load) rdq.push_back(v.rdata);
            if (v.e_wb) wbq.push_back('{v.regd, v.e_data});
        end
        exs_lsq_push_i      = 1'b1;
        exs_lsq_load_i      = v.load;
        exs_lsq_funct3_i    = v.f3;
        exs_lsq_addr_i      = v.addr;
        exs_lsq_wdata_i     = v.wdata;
        exs_lsq_regd_addr_i = v.regd;
        tick();
        exs_lsq_push_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (busq.size() == 0 && wbq.size() == 0 && rv_cnt == 0 && lsq_empty_o && !lsq_reg_wr_o) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("drain_done", {31'b0, done}, 32'd1);
    endtask

    // Memory slave: checks each requesting cycle against the head expectation, grants
    // per gnt_en/stall, and returns read data rv_delay cycles after a load grant.
    initial begin
        bus_exp_t b;
        mem_if.mem_gnt_i    = 1'b0;
        mem_if.mem_rvalid_i = 1'b0;
        mem_if.mem_rdata_i  = '0;
        forever begin
            @(posedge clk_i);
            #2;
            mem_if.mem_gnt_i    = 1'b0;
            mem_if.mem_rvalid_i = 1'b0;
            if (spur) begin
                mem_if.mem_rvalid_i = 1'b1;
                mem_if.mem_rdata_i  = 32'h1357_9BDF;
                spur = 1'b0;
            end
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_if.mem_rvalid_i = 1'b1;
                    mem_if.mem_rdata_i  = rv_data;
                end
            end
            if (mem_if.mem_req_o) begin
                req_cycles++;
                if (busq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_req: got addr %h, expected no request", mem_if.mem_addr_o);
                end else begin
                    b = busq[0];
                    checkOutput("bus_we", {31'b0, mem_if.mem_we_o}, {31'b0, b.we});
                    checkOutput("bus_addr", mem_if.mem_addr_o, b.addr);
                    checkOutput("bus_be", {28'b0, mem_if.mem_be_o}, {28'b0, b.be});
                    if (b.we) checkOutput("bus_wdata", mem_if.mem_wdata_o, b.wdata);
                    if (gnt_en) begin
                        if (stall > 0) begin
                            stall--;
                        end else begin
                            mem_if.mem_gnt_i = 1'b1;
                            grants++;
                            void'(busq.pop_front());
                            if (!b.we) begin
                                if (rdq.size() == 0) begin
                                    checks++;
                                    errors++;
                                    $display("[TB] FAIL rdata_queue: got empty, expected an entry");
                                end else begin
                                    rv_data = rdq.pop_front();
                                end
                                rv_cnt = rv_delay;
                            end
                        end
                    end
                end
            end
        end
    end

    // Write-back monitor.
    initial begin
        wb_exp_t w;
        forever begin
            @(posedge clk_i);
            #1;
            if (lsq_reg_wr_o) begin
                wb_count++;
                if (wbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_wb: got reg %0d data %h, expected none", lsq_reg_addr_o, lsq_reg_data_o);
                end else begin
                    w = wbq.pop_front();
                    checkOutput("wb_addr", {27'b0, lsq_reg_addr_o}, {27'b0, w.regd});
                    checkOutput("wb_data", lsq_reg_data_o, w.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[12];
        vec_t fv[5];
        vec_t sv;
        int   r0;
        int   g0;
        int   w0;

        vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'h0,        5'd5,  32'hDEADBEEF, 32'h100, 4'b1111, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 3'b000, 32'h203, 32'h000000A5, 5'd0,  32'h0,        32'h200, 4'b1000, 32'hA5A5A5A5, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 3'b000, 32'h102, 32'h0,        5'd6,  32'h00800000, 32'h100, 4'b1111, 32'h0,        1'b1, 32'hFFFFFF80};
        vecs[3]  = '{1'b1, 3'b100, 32'h102, 32'h0,        5'd7,  32'h00800000, 32'h100, 4'b1111, 32'h0,        1'b1, 32'h00000080};
        vecs[4]  = '{1'b1, 3'b001, 32'h102, 32'h0,        5'd8,  32'h80011234, 32'h100, 4'b1111, 32'h0,        1'b1, 32'hFFFF8001};
        vecs[5]  = '{1'b1, 3'b101, 32'h000, 32'h0,        5'd9,  32'h1234F00D, 32'h000, 4'b1111, 32'h0,        1'b1, 32'h0000F00D};
        vecs[6]  = '{1'b0, 3'b001, 32'h302, 32'h0000BEEF, 5'd0,  32'h0,        32'h300, 4'b1100, 32'hBEEFBEEF, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 3'b010, 32'h404, 32'h12345678, 5'd0,  32'h0,        32'h404, 4'b1111, 32'h12345678, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 3'b010, 32'h500, 32'h0,        5'd0,  32'h00000055, 32'h500, 4'b1111, 32'h0,        1'b0, 32'h0};
        vecs[9]  = '{1'b0, 3'b000, 32'h001, 32'hFFFFFF3C, 5'd0,  32'h0,        32'h000, 4'b0010, 32'h3C3C3C3C, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 3'b000, 32'h003, 32'h0,        5'd10, 32'h7F000000, 32'h000, 4'b1111, 32'h0,        1'b1, 32'h0000007F};
        vecs[11] = '{1'b1, 3'b001, 32'h000, 32'h0,        5'd31, 32'hFFFF8000, 32'h000, 4'b1111, 32'h0,        1'b1, 32'hFFFF8000};

        fv[0] = '{1'b0, 3'b010, 32'h010, 32'h11111111, 5'd0, 32'h0,        32'h010, 4'b1111, 32'h11111111, 1'b0, 32'h0};
        fv[1] = '{1'b0, 3'b010, 32'h014, 32'h22222222, 5'd0, 32'h0,        32'h014, 4'b1111, 32'h22222222, 1'b0, 32'h0};
        fv[2] = '{1'b1, 3'b010, 32'h018, 32'h0,        5'd3, 32'hCAFEF00D, 32'h018, 4'b1111, 32'h0,        1'b1, 32'hCAFEF00D};
        fv[3] = '{1'b0, 3'b000, 32'h01D, 32'h00000077, 5'd0, 32'h0,        32'h01C, 4'b0010, 32'h77777777, 1'b0, 32'h0};
        fv[4] = '{1'b0, 3'b010, 32'h020, 32'h55555555, 5'd0, 32'h0,        32'h020, 4'b1111, 32'h55555555, 1'b0, 32'h0};

        clk_en_i            = 1'b1;
        resetb_i            = 1'b0;
        exs_lsq_push_i      = 1'b0;
        exs_lsq_load_i      = 1'b0;
        exs_lsq_funct3_i    = 3'b000;
        exs_lsq_addr_i      = '0;
        exs_lsq_wdata_i     = '0;
        exs_lsq_regd_addr_i = '0;

        #3;
        checkOutput("rst_req", {31'b0, mem_if.mem_req_o}, 32'd0);
        checkOutput("rst_full", {31'b0, exs_lsq_full_o}, 32'd0);
        checkOutput("rst_empty", {31'b0, lsq_empty_o}, 32'd1);
        checkOutput("rst_wb", {31'b0, lsq_reg_wr_o}, 32'd0);
        checkOutput("rst_be", {28'b0, mem_if.mem_be_o}, 32'd0);
        checkOutput("rst_addr", mem_if.mem_addr_o, 32'd0);
        tick();
        tick();
        resetb_i = 1'b1;
        tick();

        $display("[TB] table vectors");
        for (int i = 0; i < 12; i++) begin
            r0 = req_cycles;
            applyStimulus(vecs[i], 1'b1);
            drain(40);
            checkOutput($sformatf("req_cycles_v%0d", i), req_cycles - r0, 32'd1);
        end

        $display("[TB] fill queue with grant held off");
        gnt_en = 1'b0;
        g0 = grants;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(fv[k], 1'b1);
            checkOutput($sformatf("full_after_push%0d", k + 1), {31'b0, exs_lsq_full_o}, (k == 3) ? 32'd1 : 32'd0);
        end
        applyStimulus(fv[4], 1'b0);
        checkOutput("full_after_drop", {31'b0, exs_lsq_full_o}, 32'd1);
        gnt_en = 1'b1;
        drain(80);
        checkOutput("full_grants", grants - g0, 32'd4);
        checkOutput("full_cleared", {31'b0, exs_lsq_full_o}, 32'd0);

        $display("[TB] stalled halfword store");
        sv = '{1'b0, 3'b001, 32'h306, 32'h0000ABCD, 5'd0, 32'h0, 32'h304, 4'b1100, 32'hABCDABCD, 1'b0, 32'h0};
        stall = 3;
        r0 = req_cycles;
        applyStimulus(sv, 1'b1);
        drain(40);
        checkOutput("stall_req_cycles", req_cycles - r0, 32'd4);

        $display("[TB] spurious rvalid in idle");
        w0 = wb_count;
        spur = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("spur_no_wb", wb_count - w0, 32'd0);
        checkOutput("spur_empty", {31'b0, lsq_empty_o}, 32'd1);

        $display("[TB] push with clock enable low");
        clk_en_i = 1'b0;
        applyStimulus(sv, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("clken_empty_frozen", {31'b0, lsq_empty_o}, 32'd1);
        clk_en_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("clken_no_req", {31'b0, mem_if.mem_req_o}, 32'd0);
        checkOutput("clken_empty_after", {31'b0, lsq_empty_o}, 32'd1);

        $display("[TB] reset while waiting for read data");
        rv_delay = 6;
        g0 = grants;
        sv = '{1'b1, 3'b010, 32'h600, 32'h0, 5'd12, 32'h0BADF00D, 32'h600, 4'b1111, 32'h0, 1'b1, 32'h0BADF00D};
        applyStimulus(sv, 1'b1);
        for (int i = 0; i < 20 && grants == g0; i++) tick();
        checkOutput("rstwait_granted", grants - g0, 32'd1);
        tick();
        w0 = wb_count;
        resetb_i = 1'b0;
        busq.delete();
        wbq.delete();
        rdq.delete();
        tick();
        resetb_i = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checkOutput("rstwait_rv_done", rv_cnt, 32'd0);
        checkOutput("rstwait_no_wb", wb_count - w0, 32'd0);
        checkOutput("rstwait_req", {31'b0, mem_if.mem_req_o}, 32'd0);
        checkOutput("rstwait_empty", {31'b0, lsq_empty_o}, 32'd1);
        checkOutput("rstwait_full", {31'b0, exs_lsq_full_o}, 32'd0);
        rv_delay = 2;

        $display("[TB] operation after reset");
        r0 = req_cycles;
        applyStimulus(vecs[0], 1'b1);
        drain(40);
        checkOutput("post_rst_req_cycles", req_cycles - r0, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsq_ctrl.md
Name: lsq_ctrl

Overview:
Load/store queue controller between the ex stage and the single data-memory port. It buffers memory ops issued by ex in order and sequences them onto the bus one at a time. It returns load data, sign- or zero-extended, to integer regfile write port b. That write-back also clears the id-stage pending-load flag for the target register.

Parameters:
C_XLEN, 32, data/address width; only 32 supported
C_DEPTH, 4, queue entries; power of two, >= 2

Ports:
clk_i  in  1  clock
clk_en_i  in  1  clock enable; all state advances only when high
resetb_i  in  1  reset
exs_lsq_push_i  in  1  ex pushes one memory op this cycle
exs_lsq_full_o  out  1  queue full; push ignored while high
exs_lsq_load_i  in  1  1 = load, 0 = store
exs_lsq_funct3_i  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
exs_lsq_addr_i  in  C_XLEN  byte address, naturally aligned (ex guarantees)
exs_lsq_wdata_i  in  C_XLEN  store data, right-justified
exs_lsq_regd_addr_i  in  5  load destination register
lsq_empty_o  out  1  queue empty and bus idle
mem_req_o  out  1  bus request
mem_gnt_i  in  1  bus grant
mem_we_o  out  1  write enable
mem_addr_o  out  C_XLEN  word address (addr[1:0] forced 0)
mem_be_o  out  4  byte enables
mem_wdata_o  out  C_XLEN  lane-aligned store data
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  C_XLEN  read data
lsq_reg_wr_o  out  1  regfile port-b write
lsq_reg_addr_o  out  5  write register
lsq_reg_data_o  out  C_XLEN  extended load data

Behaviour:
- Reset: asynchronous, active-low; queue flushed (rd/wr pointers 0, count 0); FSM IDLE; mem_req_o, lsq_reg_wr_o, exs_lsq_full_o = 0; lsq_empty_o = 1; other outputs 0.
- Queue: circular FIFO, pointers wrap modulo C_DEPTH. Count is a registered value with range 0..C_DEPTH. exs_lsq_full_o = (count == C_DEPTH), registered.
- Push while full is dropped. Push and pop in the same cycle leave count unchanged. When full, a same-cycle pop does not admit the push.
- FSM IDLE: if count != 0, go to REQ next cycle. The bus fields are registered from the head entry. Push-to-mem_req_o latency is at least 2 cycles.
- FSM REQ: mem_req_o = 1; addr, we, be and wdata are held stable until mem_gnt_i.
  - Grant on a store: pop; go to REQ if count > 1, else IDLE.
  - Grant on a load: go to WAIT; mem_req_o drops next cycle.
- FSM WAIT: mem_req_o = 0. mem_rvalid_i is accepted only in WAIT; rvalid in other states is ignored. On rvalid: pop, and go to REQ if count > 1, else IDLE.
- One transaction outstanding at most; strict program order.
- Byte lanes, with off = addr[1:0]:
  - SB: be = 0001 << off; data byte replicated to all 4 lanes.
  - SH: be = 0011 << off; halfword replicated to both halves.
  - SW: be = 1111.
  - Loads: be = 1111.
- Load extract: shift rdata right by 8*off, then extend. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Write-back timing: registered. lsq_reg_wr_o pulses for one cycle, the cycle after the accepted rvalid, with the head's regd address.
- Loads to x0: the bus access is still performed; lsq_reg_wr_o is suppressed.
- lsq_empty_o = (count == 0) & IDLE.
- clk_en_i low: everything frozen, including the grant/rvalid sampling.
- Reset mid-transaction: the transaction is abandoned; a later rvalid is ignored because the FSM is in IDLE.

Test Plan:
- Push LW x5 @0x100; gnt on 1st req cycle; rvalid 2 cycles later with rdata 0xDEADBEEF -> one mem_req_o cycle (we=0, be=1111, addr=0x100); lsq_reg_wr_o=1, addr 5, data 0xDEADBEEF one cycle after rvalid.
- SB @0x203 wdata 0x000000A5 -> mem_addr_o=0x200, be=1000, wdata=0xA5A5A5A5; no write-back; lsq_empty_o returns 1.
- LB @0x102 and LBU @0x102, rdata 0x00800000 -> data 0xFFFFFF80 and 0x00000080 respectively.
- Push 5 ops with gnt held low, C_DEPTH=4 -> full=1 after 4th push; 5th dropped; after releasing gnt exactly 4 bus transactions occur, in order.
- Stall gnt for 3 cycles during a SH -> addr/be/wdata constant throughout; spurious rvalid while in IDLE -> no lsq_reg_wr_o.
- Assert resetb_i low while in WAIT, then deliver rvalid -> no write-back; count=0, mem_req_o=0, lsq_empty_o=1.
